// File: rtl/nmos_clk_pkg.sv
// Shared types and defaults for the two-phase non-overlapping clock-enable generator.
package nmos_clk_pkg;

  typedef enum logic [1:0] {
    S_P1 = 2'd0,
    S_G1 = 2'd1,
    S_P2 = 2'd2,
    S_G2 = 2'd3
  } state_t;

  localparam int DEF_PH1_LEN = 2;
  localparam int DEF_PH2_LEN = 2;
  localparam int DEF_GAP_LEN = 1;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_LEN_W   = 8;

  // Full C1/C2 period in main_clk cycles, ignoring HALT stretch.
  function automatic int clk_period(input int ph1, input int ph2, input int gap);
    return ph1 + ph2 + 2 * gap;
  endfunction

endpackage

// File: rtl/nmos_phase_timer.sv
// Phase down-counter: loads on state entry, decrements to zero, and optionally holds.
module nmos_phase_timer #(
  parameter int LEN_W = 8
) (
  input  logic             main_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             hold,
  output logic [LEN_W-1:0] count,
  output logic             expired
);

  // Reset leaves the counter at zero so the first post-reset edge sees an expired timer.
  always_ff @(posedge main_clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/nmos_clk_gen.sv
// Two-phase non-overlapping C1/C2 qualifier generator with HALT stretch and cycle counter.
// Optional single-step control (STEP_MODE/STEP) is built when NMOS_CLK_STEP_EN is defined.
module nmos_clk_gen
  import nmos_clk_pkg::*;
#(
  parameter int PH1_LEN = DEF_PH1_LEN,
  parameter int PH2_LEN = DEF_PH2_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             main_clk,
  input  logic             R,
  input  logic             HALT,
`ifdef NMOS_CLK_STEP_EN
  input  logic             STEP_MODE,
  input  logic             STEP,
`endif
  output logic             C1,
  output logic             C2,
  output logic             C1_P,
  output logic             C2_P,
  output logic             SYNC,
  output logic [CNT_W-1:0] CYC_CNT,
  output state_t           dbg_state
);

  localparam int PERIOD = clk_period(PH1_LEN, PH2_LEN, GAP_LEN);
  localparam logic [LEN_W-1:0] PH1_V = LEN_W'(PH1_LEN - 1);
  localparam logic [LEN_W-1:0] PH2_V = LEN_W'(PH2_LEN - 1);
  localparam logic [LEN_W-1:0] GAP_V = (GAP_LEN > 0) ? LEN_W'(GAP_LEN - 1) : '0;

  if (PH1_LEN < 1 || PH2_LEN < 1 || GAP_LEN < 0 || PERIOD < 2 ||
      PH1_LEN >= (1 << LEN_W) || PH2_LEN >= (1 << LEN_W) || GAP_LEN >= (1 << LEN_W))
  begin : g_bad_len
    $error("nmos_clk_gen: illegal phase length parameters");
  end

  state_t             state, state_n;
  logic               stretch, stretch_n;
  logic               t_load, t_hold, t_expired;
  logic [LEN_W-1:0]   t_val, t_count;
  logic               cnt_inc;
  logic               go_p1;
  logic [CNT_W-1:0]   cyc_cnt;

  nmos_phase_timer #(.LEN_W(LEN_W)) u_timer (
    .main_clk (main_clk),
    .rst      (R),
    .load     (t_load),
    .load_val (t_val),
    .hold     (t_hold),
    .count    (t_count),
    .expired  (t_expired)
  );

`ifdef NMOS_CLK_STEP_EN
  logic step_q, step_pend, leave_g2;

  // A STEP rising edge seen while a cycle is running is remembered for the next S_G2 exit.
  assign go_p1    = !STEP_MODE || STEP || step_pend;
  assign leave_g2 = (state == S_G2) && t_expired && go_p1;

  always_ff @(posedge main_clk) begin
    if (R) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= STEP;
      if (!STEP_MODE || leave_g2) begin
        step_pend <= 1'b0;
      end else if (STEP && !step_q) begin
        step_pend <= 1'b1;
      end
    end
  end
`else
  assign go_p1 = 1'b1;
`endif

  always_comb begin
    state_n   = state;
    stretch_n = 1'b0;
    t_load    = 1'b0;
    t_hold    = 1'b0;
    t_val     = '0;
    cnt_inc   = 1'b0;
    case (state)
      S_P1: if (t_expired) begin
        if (HALT) begin
          t_hold    = 1'b1;
          stretch_n = 1'b1;
        end else if (GAP_LEN == 0) begin
          state_n = S_P2;
          t_load  = 1'b1;
          t_val   = PH2_V;
        end else begin
          state_n = S_G1;
          t_load  = 1'b1;
          t_val   = GAP_V;
        end
      end
      S_G1: if (t_expired) begin
        state_n = S_P2;
        t_load  = 1'b1;
        t_val   = PH2_V;
      end
      S_P2: if (t_expired) begin
        cnt_inc = 1'b1;
        t_load  = 1'b1;
        if (GAP_LEN == 0) begin
          state_n = S_P1;
          t_val   = PH1_V;
        end else begin
          state_n = S_G2;
          t_val   = GAP_V;
        end
      end
      S_G2: if (t_expired && go_p1) begin
        state_n = S_P1;
        t_load  = 1'b1;
        t_val   = PH1_V;
      end
      default: state_n = S_G2;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (R) begin
      state   <= S_G2;
      stretch <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      state   <= state_n;
      stretch <= stretch_n;
      if (cnt_inc) cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

  // stretch keeps C1_P from re-firing while HALT holds a single-cycle PHI1.
  assign C1        = (state == S_P1);
  assign C2        = (state == S_P2);
  assign C1_P      = C1 && (t_count == PH1_V) && !stretch;
  assign C2_P      = C2 && (t_count == PH2_V);
  assign SYNC      = C2 && t_expired;
  assign CYC_CNT   = cyc_cnt;
  assign dbg_state = state;

`ifndef SYNTHESIS
  always_ff @(posedge main_clk) begin
    assert (!(C1 && C2));
    assert (!C1_P || C1);
    assert (!C2_P || C2);
  end
`endif

endmodule

// File: tb/tb_nmos_clk_gen.sv
// Scoreboard bench for nmos_clk_gen: three parameterisations driven by directed cycle vectors.
module tb_nmos_clk_gen;
  import nmos_clk_pkg::*;

  logic main_clk;
  logic r0, r1, r2;
  logic halt0, halt1;
  logic zero;
`ifdef NMOS_CLK_STEP_EN
  logic step_mode, step;
`endif

  logic        c1_0, c2_0, c1p_0, c2p_0, sync_0;
  logic        c1_1, c2_1, c1p_1, c2p_1, sync_1;
  logic        c1_2, c2_2, c1p_2, c2p_2, sync_2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  state_t      dbg0, dbg1, dbg2;

  logic [22:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  // clock/reset block
  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  nmos_clk_gen u0 (
    .main_clk(main_clk), .R(r0), .HALT(halt0),
`ifdef NMOS_CLK_STEP_EN
    .STEP_MODE(step_mode), .STEP(step),
`endif
    .C1(c1_0), .C2(c2_0), .C1_P(c1p_0), .C2_P(c2p_0), .SYNC(sync_0),
    .CYC_CNT(cnt0), .dbg_state(dbg0)
  );

  nmos_clk_gen #(.PH1_LEN(1), .PH2_LEN(3), .GAP_LEN(0)) u1 (
    .main_clk(main_clk), .R(r1), .HALT(halt1),
`ifdef NMOS_CLK_STEP_EN
    .STEP_MODE(zero), .STEP(zero),
`endif
    .C1(c1_1), .C2(c2_1), .C1_P(c1p_1), .C2_P(c2p_1), .SYNC(sync_1),
    .CYC_CNT(cnt1), .dbg_state(dbg1)
  );

  nmos_clk_gen #(.CNT_W(4)) u2 (
    .main_clk(main_clk), .R(r2), .HALT(zero),
`ifdef NMOS_CLK_STEP_EN
    .STEP_MODE(zero), .STEP(zero),
`endif
    .C1(c1_2), .C2(c2_2), .C1_P(c1p_2), .C2_P(c2p_2), .SYNC(sync_2),
    .CYC_CNT(cnt2), .dbg_state(dbg2)
  );

  // driver tasks: inputs sampled at the next edge, expected outputs after that edge queued.
  // Flags are {C1, C2, C1_P, C2_P, SYNC}; DUTs not selected are held in reset.
  task automatic cyc(input int sel, input logic r, input logic h,
                     input logic [4:0] fl, input int cnt, input string tag);
    r0    = (sel == 0) ? r : 1'b1;
    r1    = (sel == 1) ? r : 1'b1;
    r2    = (sel == 2) ? r : 1'b1;
    halt0 = (sel == 0) ? h : 1'b0;
    halt1 = (sel == 1) ? h : 1'b0;
    @(posedge main_clk);
    #1;
    exp_q.push_back({2'(sel), fl, 16'(cnt)});
    tag_q.push_back(tag);
  endtask

  // One undisturbed period of a PH1=2, PH2=2, GAP=1 device, starting from expired S_G2.
  task automatic period6(input int sel, input int c0, input int mask);
    cyc(sel, 1'b0, 1'b0, 5'b10100, c0, "p1_entry");
    cyc(sel, 1'b0, 1'b0, 5'b10000, c0, "p1_last");
    cyc(sel, 1'b0, 1'b0, 5'b00000, c0, "gap1");
    cyc(sel, 1'b0, 1'b0, 5'b01010, c0, "p2_entry");
    cyc(sel, 1'b0, 1'b0, 5'b01001, c0, "p2_sync");
    cyc(sel, 1'b0, 1'b0, 5'b00000, (c0 + 1) & mask, "gap2_cnt");
  endtask

  // scoreboard monitor
  always @(negedge main_clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e;
      string       t;
      logic [4:0]  af;
      logic [15:0] ac;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      case (e[22:21])
        2'd0:    begin af = {c1_0, c2_0, c1p_0, c2p_0, sync_0}; ac = cnt0; end
        2'd1:    begin af = {c1_1, c2_1, c1p_1, c2p_1, sync_1}; ac = cnt1; end
        default: begin af = {c1_2, c2_2, c1p_2, c2p_2, sync_2}; ac = {12'd0, cnt2}; end
      endcase
      checks++;
      if (af !== e[20:16] || ac !== e[15:0]) begin
        errors++;
        $display("FAIL %s dut=%0d got flags=%05b cnt=%0d expected flags=%05b cnt=%0d",
                 t, e[22:21], af, ac, e[20:16], e[15:0]);
      end
    end
  end

  initial begin
    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    halt0 = 1'b0; halt1 = 1'b0; zero = 1'b0;
`ifdef NMOS_CLK_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif

    // defaults: reset, then two free-running periods
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 5'b00000, 0, "reset_out");
    @(negedge main_clk);
    checks++;
    if (dbg0 !== S_G2) begin
      errors++;
      $display("FAIL reset_state got=%0d expected=%0d", dbg0, S_G2);
    end
    period6(0, 0, 16'hffff);
    period6(0, 1, 16'hffff);

    // HALT sampled 1 on the last P1 cycle for 5 edges stretches C1 to 7 cycles
    cyc(0, 1'b0, 1'b0, 5'b10100, 2, "halt_p1_entry");
    cyc(0, 1'b0, 1'b0, 5'b10000, 2, "halt_p1_last");
    for (int i = 0; i < 5; i++) cyc(0, 1'b0, 1'b1, 5'b10000, 2, "halt_stretch");
    cyc(0, 1'b0, 1'b0, 5'b00000, 2, "halt_gap");
    cyc(0, 1'b0, 1'b0, 5'b01010, 2, "halt_p2_entry");
    cyc(0, 1'b0, 1'b0, 5'b01001, 2, "halt_p2_sync");
    cyc(0, 1'b0, 1'b0, 5'b00000, 3, "halt_cnt");

    // HALT outside the last P1 cycle is ignored
    cyc(0, 1'b0, 1'b1, 5'b10100, 3, "halt_ign_g2");
    cyc(0, 1'b0, 1'b1, 5'b10000, 3, "halt_ign_p1");
    cyc(0, 1'b0, 1'b0, 5'b00000, 3, "halt_ign_gap");
    cyc(0, 1'b0, 1'b1, 5'b01010, 3, "halt_ign_g1");
    cyc(0, 1'b0, 1'b1, 5'b01001, 3, "halt_ign_p2");
    cyc(0, 1'b0, 1'b1, 5'b00000, 4, "halt_ign_cnt");

    // R in the second C2 cycle aborts the phase and clears the counter
    cyc(0, 1'b0, 1'b0, 5'b10100, 4, "rmid_p1");
    cyc(0, 1'b0, 1'b0, 5'b10000, 4, "rmid_p1_last");
    cyc(0, 1'b0, 1'b0, 5'b00000, 4, "rmid_gap");
    cyc(0, 1'b0, 1'b0, 5'b01010, 4, "rmid_c2_first");
    cyc(0, 1'b0, 1'b0, 5'b01001, 4, "rmid_c2_second");
    cyc(0, 1'b1, 1'b0, 5'b00000, 0, "rmid_reset");
    cyc(0, 1'b1, 1'b0, 5'b00000, 0, "rmid_reset_hold");
    period6(0, 0, 16'hffff);

    // PH1=1, PH2=3, GAP=0: period 4, C2 right after C1, SYNC on third C2 cycle
    cyc(1, 1'b1, 1'b0, 5'b00000, 0, "g0_reset");
    cyc(1, 1'b1, 1'b0, 5'b00000, 0, "g0_reset");
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1'b0, 1'b0, 5'b10100, k, "g0_p1");
      cyc(1, 1'b0, 1'b0, 5'b01010, k, "g0_p2_entry");
      cyc(1, 1'b0, 1'b0, 5'b01000, k, "g0_p2_mid");
      cyc(1, 1'b0, 1'b0, 5'b01001, k, "g0_p2_sync");
    end
    // single-cycle PHI1 stretched by HALT must not re-pulse C1_P
    cyc(1, 1'b0, 1'b0, 5'b10100, 3, "g0_halt_entry");
    cyc(1, 1'b0, 1'b1, 5'b10000, 3, "g0_halt_no_repulse");
    cyc(1, 1'b0, 1'b1, 5'b10000, 3, "g0_halt_no_repulse");
    cyc(1, 1'b0, 1'b0, 5'b01010, 3, "g0_halt_p2");
    cyc(1, 1'b0, 1'b0, 5'b01000, 3, "g0_halt_p2_mid");
    cyc(1, 1'b0, 1'b0, 5'b01001, 3, "g0_halt_sync");
    cyc(1, 1'b0, 1'b0, 5'b10100, 4, "g0_halt_cnt");

    // CNT_W=4: 17 periods wrap 15 -> 0 and end at 1
    cyc(2, 1'b1, 1'b0, 5'b00000, 0, "w4_reset");
    cyc(2, 1'b1, 1'b0, 5'b00000, 0, "w4_reset");
    for (int k = 0; k < 17; k++) period6(2, k & 15, 15);

`ifdef NMOS_CLK_STEP_EN
    // step mode: one full cycle per STEP pulse, pulses 20 cycles apart
    step_mode = 1'b1;
    cyc(0, 1'b1, 1'b0, 5'b00000, 0, "step_reset");
    cyc(0, 1'b1, 1'b0, 5'b00000, 0, "step_reset");
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 5'b00000, 0, "step_wait");
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      cyc(0, 1'b0, 1'b0, 5'b10100, p, "step_p1");
      step = 1'b0;
      cyc(0, 1'b0, 1'b0, 5'b10000, p, "step_p1_last");
      cyc(0, 1'b0, 1'b0, 5'b00000, p, "step_gap1");
      cyc(0, 1'b0, 1'b0, 5'b01010, p, "step_p2");
      cyc(0, 1'b0, 1'b0, 5'b01001, p, "step_sync");
      for (int i = 0; i < 15; i++) cyc(0, 1'b0, 1'b0, 5'b00000, p + 1, "step_idle");
    end
    step_mode = 1'b0;
`endif

    repeat (2) @(posedge main_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
